mc_control_fsm: RTL and testbench

Multicycle sequencing controller for the MIPS datapath. It decodes the 6-bit opcode held in the instruction register and steps the shared datapath (single memory, single ALU, register file) through fetch, decode, execute, memory and write-back states, one state per clock. It supports variable memory latency through a `mem_ready` handshake. It also keeps a retired-instruction counter and a sticky illegal-opcode flag.

---
 rtl/mc_control_fsm.sv | 173 +++++++++++++++++
 tb/tb_mc_control_fsm.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS sequencing controller: steps the shared datapath through
// fetch/decode/execute/memory/write-back with a mem_ready stall handshake.
module mc_control_fsm #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             IRWrite,
  output logic             ALUSrcA,
  output logic             RegWrite,
  output logic             RegDst,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count,
  output logic             illegal_op
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTEXE   = 4'd6,
    S_RTWB    = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_ILLEGAL = 4'd12
  } state_e;

  state_e           r_state;
  logic [CNT_W-1:0] r_count;
  logic             r_illegal;
  logic             r_is_lw;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; the reset branch is synchronous by design.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_FETCH;
      r_count   <= '0;
      r_illegal <= 1'b0;
      r_is_lw   <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH:  if (mem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          // opcode is only trusted here, so lw/sw is remembered for MEMADR.
          r_is_lw <= (opcode == OP_LW);
          case (opcode)
            OP_LW, OP_SW: r_state <= S_MEMADR;
            OP_RTYPE:     r_state <= S_RTEXE;
            OP_BEQ:       r_state <= S_BRANCH;
            OP_ADDI:      r_state <= S_ADDIEX;
            OP_J:         r_state <= S_JUMP;
            default: begin
              r_state   <= S_ILLEGAL;
              r_illegal <= 1'b1;
            end
          endcase
        end
        S_MEMADR: r_state <= r_is_lw ? S_MEMRD : S_MEMWR;
        S_MEMRD:  if (mem_ready) r_state <= S_MEMWB;
        S_MEMWR: begin
          if (mem_ready) begin
            r_state <= S_FETCH;
            r_count <= r_count + 1'b1;
          end
        end
        S_RTEXE:  r_state <= S_RTWB;
        S_ADDIEX: r_state <= S_ADDIWB;
        S_MEMWB, S_RTWB, S_ADDIWB, S_BRANCH, S_JUMP: begin
          r_state <= S_FETCH;
          r_count <= r_count + 1'b1;
        end
        default:  r_state <= S_FETCH;
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    if (reset) begin
      case (r_state)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        S_DECODE: ALUSrcB = 2'b11;
        S_MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEMWB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        S_MEMWR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        S_RTEXE: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
        end
        S_RTWB: begin
          RegWrite = 1'b1;
          RegDst   = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 2'b01;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
        end
        S_ADDIEX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_ADDIWB: RegWrite = 1'b1;
        S_JUMP: begin
          PCWrite  = 1'b1;
          PCSource = 2'b10;
        end
        default: ;
      endcase
    end
  end

  assign state       = reset ? r_state : 4'd0;
  assign instr_count = r_count;
  assign illegal_op  = r_illegal;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: directed table, corner sequences and
// randomized instruction stream against an instruction-level reference model.
module tb_mc_control_fsm;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [5:0]       opcode;
  logic             mem_ready;
  logic             PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
  logic             IRWrite, ALUSrcA, RegWrite, RegDst;
  logic [1:0]       ALUSrcB, ALUOp, PCSource;
  logic [3:0]       state;
  logic [CNT_W-1:0] instr_count;
  logic             illegal_op;

  int checks = 0;
  int errors = 0;

  logic [CNT_W-1:0] m_cnt;
  logic             m_ill;

  mc_control_fsm #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite), .RegDst(RegDst),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource), .state(state),
    .instr_count(instr_count), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  wire [15:0] dut_ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
                          IRWrite, ALUSrcA, RegWrite, RegDst, ALUSrcB, ALUOp, PCSource};
  wire [24:0] dut_all  = {state, dut_ctrl, instr_count, illegal_op};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Control table, one row per state, in dut_ctrl bit order.
  function automatic logic [15:0] exp_ctrl(input int s, input logic mr);
    logic pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd;
    logic [1:0] asb, aop, pcs;
    {pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd} = '0;
    {asb, aop, pcs} = '0;
    case (s)
      0:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
      1:  asb = 2'b11;
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mrd = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mwr = 1; iord = 1; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rw = 1; rd = 1; end
      8:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
      9:  begin asa = 1; asb = 2'b10; end
      10: rw = 1;
      11: begin pcw = 1; pcs = 2'b10; end
      default: ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd, asb, aop, pcs};
  endfunction

  // One clock: drive inputs, compare every output against the model, advance.
  task automatic cyc(input string name, input logic [5:0] op, input logic mr, input int s);
    opcode    = op;
    mem_ready = mr;
    if (s == 12) m_ill = 1'b1;
    #2;
    check(name, 32'(dut_all), 32'({4'(s), exp_ctrl(s, mr), m_cnt, m_ill}));
    @(posedge clk);
    #1;
  endtask

  // Instruction-level model: the phases each opcode walks through, with
  // the requested number of memory stalls in the fetch and memory phases.
  task automatic run_instr(input logic [5:0] op, input int fst, input int mst);
    int post[$];
    for (int i = 0; i < fst; i++) cyc("fetch_stall", 6'($urandom), 1'b0, 0);
    cyc("fetch", 6'($urandom), 1'b1, 0);
    cyc("decode", op, 1'($urandom), 1);
    case (op)
      6'b100011: post = '{2, 3, 4};
      6'b101011: post = '{2, 5};
      6'b000000: post = '{6, 7};
      6'b001000: post = '{9, 10};
      6'b000100: post = '{8};
      6'b000010: post = '{11};
      default:   post = '{12};
    endcase
    foreach (post[k]) begin
      if (post[k] == 3 || post[k] == 5) begin
        for (int i = 0; i < mst; i++) cyc("mem_stall", 6'($urandom), 1'b0, post[k]);
        cyc("mem", 6'($urandom), 1'b1, post[k]);
      end else begin
        cyc("exec", 6'($urandom), 1'($urandom), post[k]);
      end
    end
    if (post[0] != 12) m_cnt = m_cnt + 1'b1;
  endtask

  typedef struct {
    logic [5:0]       op;
    int               fst;
    int               mst;
    logic [CNT_W-1:0] cnt_after;
    logic             ill_after;
  } vec_t;

  vec_t tbl[9];
  logic [5:0] legal_ops[6];

  initial begin
    tbl[0] = '{6'b100011, 0, 0, 4'd1, 1'b0};  // lw
    tbl[1] = '{6'b101011, 0, 2, 4'd2, 1'b0};  // sw, two MEMWR stalls
    tbl[2] = '{6'b000000, 0, 0, 4'd3, 1'b0};  // R-type
    tbl[3] = '{6'b001000, 0, 0, 4'd4, 1'b0};  // addi
    tbl[4] = '{6'b000100, 0, 0, 4'd5, 1'b0};  // beq
    tbl[5] = '{6'b000010, 0, 0, 4'd6, 1'b0};  // j
    tbl[6] = '{6'b111111, 0, 0, 4'd6, 1'b1};  // illegal
    tbl[7] = '{6'b000100, 0, 0, 4'd7, 1'b1};  // beq after illegal
    tbl[8] = '{6'b100011, 1, 1, 4'd8, 1'b1};  // lw with stalls
    legal_ops = '{6'b100011, 6'b101011, 6'b000000, 6'b001000, 6'b000100, 6'b000010};

    reset     = 1'b0;
    mem_ready = 1'b1;
    opcode    = 6'b000000;
    m_cnt     = '0;
    m_ill     = 1'b0;

    // Reset hold: outputs forced quiet even with mem_ready high.
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", 32'(dut_all), 32'd0);
    reset = 1'b1;
    #2;
    check("reset_release", 32'(dut_ctrl), 32'h9210);

    foreach (tbl[i]) begin
      run_instr(tbl[i].op, tbl[i].fst, tbl[i].mst);
      check("tbl_end", 32'({state, instr_count, illegal_op}),
            32'({4'd0, tbl[i].cnt_after, tbl[i].ill_after}));
    end

    // Wrap: sixteen retirements on a 4-bit counter return it to zero.
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    m_cnt = '0;
    m_ill = 1'b0;
    repeat (16) run_instr(6'b000100, 0, 0);
    check("wrap_cnt", 32'(instr_count), 32'd0);

    // Abort a lw in MEMRD: no write-back, no retirement.
    cyc("abort_fetch", 6'($urandom), 1'b1, 0);
    cyc("abort_decode", 6'b100011, 1'b1, 1);
    cyc("abort_memadr", 6'($urandom), 1'b1, 2);
    cyc("abort_memrd", 6'($urandom), 1'b0, 3);
    reset     = 1'b0;
    mem_ready = 1'b1;
    #2;
    check("abort_quiet", 32'(dut_all), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc("abort_after", 6'($urandom), 1'b0, 0);
    check("abort_regwrite", 32'(RegWrite), 32'd0);

    // Randomized stream against the model.
    for (int n = 0; n < 150; n++) begin
      logic [5:0] op;
      if ($urandom_range(0, 4) == 0) op = 6'($urandom);
      else op = legal_ops[$urandom_range(0, 5)];
      run_instr(op, $urandom_range(0, 2), $urandom_range(0, 2));
    end
    check("final_cnt", 32'({instr_count, illegal_op}), 32'({m_cnt, m_ill}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
